gcd_arbiter: RTL and testbench

//   Shares one gcd core (go/done/ans handshake, 16-bit operands) among N_REQ requesters.

---
 rtl/gcd_arbiter.sv | 165 ++++++++++++++++
 tb/tb_gcd_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_arbiter.sv
// gcd_arbiter: round-robin front end that shares one go/done gcd core
// among N_REQ requesters, bypasses the core for zero operands and aborts
// a computation that does not finish within TIMEOUT wait cycles.
module gcd_arbiter #(
  parameter int          N_REQ   = 4,
  parameter int          WIDTH   = 16,
  parameter int          TO_W    = 20,
  parameter int unsigned TIMEOUT = 20'hFFFFF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] a_in,
  input  logic [N_REQ*WIDTH-1:0] b_in,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]       rsp_ans,
  output logic                   rsp_err,
  output logic                   busy,
  output logic [WIDTH-1:0]       gcd_a,
  output logic [WIDTH-1:0]       gcd_b,
  output logic                   gcd_go,
  output logic                   gcd_rst,
  input  logic                   gcd_done,
  input  logic [WIDTH-1:0]       gcd_ans
);

  localparam int              PTR_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [PTR_W:0]  N_EXT    = (PTR_W+1)'(N_REQ);
  localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t           r_state;
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] r_owner;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_rsp_ans;
  logic [N_REQ-1:0] r_gnt;
  logic [N_REQ-1:0] r_rsp_valid;
  logic             r_rsp_err;
  logic             r_busy;
  logic             r_go;
  logic             r_abort;
  logic [TO_W-1:0]  r_cnt;

  logic [PTR_W-1:0] w_pos [N_REQ];
  logic [N_REQ-1:0] w_cand;
  logic             w_found;
  logic [PTR_W-1:0] w_win;
  logic [WIDTH-1:0] w_a_sel;
  logic [WIDTH-1:0] w_b_sel;

  // Rotate the request vector so that candidate gi is requester ptr+1+gi (mod N_REQ)
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_rot
      logic [PTR_W:0] w_sum;
      assign w_sum      = {1'b0, r_ptr} + (PTR_W+1)'(gi + 1);
      assign w_pos[gi]  = (w_sum >= N_EXT) ? PTR_W'(w_sum - N_EXT) : PTR_W'(w_sum);
      assign w_cand[gi] = req[w_pos[gi]];
    end
  endgenerate

  // Pick the first rotated candidate; lowest rotated index wins
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_cand[i]) begin
        w_found = 1'b1;
        w_win   = w_pos[i];
      end
    end
  end

  assign w_a_sel = a_in[w_win*WIDTH +: WIDTH];
  assign w_b_sel = b_in[w_win*WIDTH +: WIDTH];

  assign gnt       = r_gnt;
  assign rsp_valid = r_rsp_valid;
  assign rsp_ans   = r_rsp_ans;
  assign rsp_err   = r_rsp_err;
  assign busy      = r_busy;
  assign gcd_a     = r_a;
  assign gcd_b     = r_b;
  assign gcd_go    = r_go;
  assign gcd_rst   = rst | r_abort;

  // Arbitration / core sequencing FSM; all outputs are registered here.
  // The grant cycle (first ISSUE cycle) is also where zero operands are
  // diverted straight to RESP; non-zero operands get go in the second
  // ISSUE cycle so the core has cleared done before WAIT starts sampling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= PTR_W'(N_REQ - 1);
      r_owner     <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_rsp_ans   <= '0;
      r_gnt       <= '0;
      r_rsp_valid <= '0;
      r_rsp_err   <= 1'b0;
      r_busy      <= 1'b0;
      r_go        <= 1'b0;
      r_abort     <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_gnt       <= '0;
      r_go        <= 1'b0;
      r_abort     <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_ans   <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_gnt   <= N_REQ'(1) << w_win;
            r_owner <= w_win;
            r_ptr   <= w_win;
            r_a     <= w_a_sel;
            r_b     <= w_b_sel;
            r_busy  <= 1'b1;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (r_a == '0 || r_b == '0) begin
            // gcd(x,0)=x and gcd(0,0)=0, both equal a|b
            r_rsp_valid <= N_REQ'(1) << r_owner;
            r_rsp_ans   <= r_a | r_b;
            r_state     <= S_RESP;
          end else if (!r_go) begin
            r_go <= 1'b1;
          end else begin
            r_cnt   <= '0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (gcd_done) begin
            r_rsp_valid <= N_REQ'(1) << r_owner;
            r_rsp_ans   <= gcd_ans;
            r_state     <= S_RESP;
          end else if (r_cnt == CNT_LAST) begin
            r_rsp_valid <= N_REQ'(1) << r_owner;
            r_rsp_err   <= 1'b1;
            r_abort     <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_arbiter.sv
// tb_gcd_arbiter: directed and random transactions against a transaction-level
// reference (Euclid gcd, round-robin pick over pending requests, fixed latencies).
module tb_gcd_arbiter;

  localparam int N   = 4;
  localparam int W   = 16;
  localparam int TMO = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [N*W-1:0]   a_in;
  logic [N*W-1:0]   b_in;
  logic [N-1:0]     gnt;
  logic [N-1:0]     rsp_valid;
  logic [W-1:0]     rsp_ans;
  logic             rsp_err;
  logic             busy;
  logic [W-1:0]     gcd_a;
  logic [W-1:0]     gcd_b;
  logic             gcd_go;
  logic             gcd_rst;
  logic             gcd_done;
  logic [W-1:0]     gcd_ans;

  logic [W-1:0]     op_a [N];
  logic [W-1:0]     op_b [N];
  logic [N-1:0]     pend;
  int               ref_ptr;
  int               core_lat;
  bit               core_hang;
  int               n_checks = 0;
  int               n_fail   = 0;

  logic             c_done;
  logic [W-1:0]     c_ans;
  int               c_rem;

  gcd_arbiter #(.N_REQ(N), .WIDTH(W), .TO_W(20), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_ans(rsp_ans), .rsp_err(rsp_err),
    .busy(busy), .gcd_a(gcd_a), .gcd_b(gcd_b), .gcd_go(gcd_go),
    .gcd_rst(gcd_rst), .gcd_done(gcd_done), .gcd_ans(gcd_ans)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_in[i*W +: W] = op_a[i];
      b_in[i*W +: W] = op_b[i];
    end
  end

  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Stand-in gcd core: done rises core_lat cycles after the go cycle, or never when hung
  assign gcd_done = c_done;
  assign gcd_ans  = c_ans;
  always @(posedge clk) begin
    if (gcd_rst) begin
      c_done <= 1'b0;
      c_rem  <= 0;
      c_ans  <= '0;
    end else if (gcd_go) begin
      c_ans  <= ref_gcd(gcd_a, gcd_b);
      c_done <= 1'b0;
      c_rem  <= core_hang ? -1 : core_lat - 1;
    end else if (c_rem > 0) begin
      c_rem <= c_rem - 1;
      if (c_rem == 1) c_done <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One arbitration round: predict the winner, follow it to its response
  task automatic expect_txn(input bit hold, input bit stop_after);
    int           win;
    int           wait_n;
    int           lat;
    int           n_go;
    int           n_rst;
    int           elat;
    logic [W-1:0] ea;
    logic [W-1:0] eb;
    logic [W-1:0] eans;
    bit           zero;
    bit           eerr;
    win = 0;
    for (int k = N; k >= 1; k--) begin
      if (pend[(ref_ptr + k) % N]) win = (ref_ptr + k) % N;
    end
    ea   = op_a[win];
    eb   = op_b[win];
    zero = (ea == 0) || (eb == 0);
    eerr = !zero && core_hang;
    eans = eerr ? '0 : ref_gcd(ea, eb);
    elat = zero ? 1 : (core_hang ? TMO + 2 : core_lat + 2);

    wait_n = 0;
    while (gnt === '0 && wait_n < 60) begin
      @(negedge clk);
      wait_n++;
    end
    chk("gnt_onehot", 32'(gnt), 32'(1) << win);
    if (!hold) begin
      req[win]  = 1'b0;
      pend[win] = 1'b0;
    end
    ref_ptr = win;

    @(negedge clk);
    lat = 1;
    chk("gnt_pulse", 32'(gnt), 0);
    chk("go_at_T1", 32'(gcd_go), 32'(!zero));
    if (!zero) chk("gcd_a_held", 32'(gcd_a), 32'(ea));
    n_go  = 0;
    n_rst = 0;
    while (rsp_valid === '0 && lat < 60) begin
      n_go  += int'(gcd_go);
      n_rst += int'(gcd_rst);
      @(negedge clk);
      lat++;
    end
    n_rst += int'(gcd_rst);
    chk("rsp_owner", 32'(rsp_valid), 32'(1) << win);
    chk("rsp_ans", 32'(rsp_ans), 32'(eans));
    chk("rsp_err", 32'(rsp_err), 32'(eerr));
    chk("rsp_latency", 32'(lat), 32'(elat));
    chk("go_count", 32'(n_go), 32'(!zero));
    chk("abort_count", 32'(n_rst), 32'(eerr));
    $display("txn owner=%0d a=%0d b=%0d ans=%0d err=%0b lat=%0d", win, ea, eb, rsp_ans, rsp_err, lat);
    if (stop_after) req = '0;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 0);
    chk("rsp_pulse", 32'(rsp_valid), 0);
  endtask

  initial begin
    int w;
    int g;
    rst       = 1'b1;
    req       = '0;
    pend      = '0;
    core_lat  = 5;
    core_hang = 1'b0;
    ref_ptr   = N - 1;
    for (int i = 0; i < N; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_go", 32'(gcd_go), 0);
    chk("rst_gcd_rst", 32'(gcd_rst), 1);
    rst = 1'b0;
    @(negedge clk);

    // single requester through the core
    op_a[0] = 48; op_b[0] = 18; core_lat = 5;
    req = 4'b0001; pend = req;
    expect_txn(0, 0);

    // all four held: rotates round robin, one response before each new grant
    for (int i = 0; i < N; i++) begin
      op_a[i] = 12; op_b[i] = 8;
    end
    req = 4'b1111; pend = req;
    for (int k = 0; k < 5; k++) expect_txn(1, k == 4);
    pend = '0;

    // zero-operand bypass
    op_a[2] = 0; op_b[2] = 35;
    req = 4'b0100; pend = req;
    expect_txn(0, 0);
    op_b[2] = 0;
    req = 4'b0100; pend = req;
    expect_txn(0, 0);

    // hung core -> timeout abort
    core_hang = 1'b1;
    op_a[1] = 100; op_b[1] = 75;
    req = 4'b0010; pend = req;
    expect_txn(0, 0);
    core_hang = 1'b0;

    // done arrives in the last allowed WAIT cycle
    core_lat = TMO;
    op_a[3] = 30; op_b[3] = 45;
    req = 4'b1000; pend = req;
    expect_txn(0, 0);

    // asynchronous reset in the middle of WAIT, then pointer restarts at requester 0
    core_hang = 1'b1;
    op_a[0] = 7; op_b[0] = 9;
    req = 4'b0001;
    w = 0;
    while (gnt === '0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("t5_pre_gnt", 32'(gnt), 1);
    req = '0;
    repeat (4) @(negedge clk);
    chk("t5_busy_wait", 32'(busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("t5_busy", 32'(busy), 0);
    chk("t5_go", 32'(gcd_go), 0);
    chk("t5_gcd_a", 32'(gcd_a), 0);
    chk("t5_gcd_rst", 32'(gcd_rst), 1);
    chk("t5_rsp", 32'({rsp_valid, rsp_err, rsp_ans}), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    core_hang = 1'b0;
    ref_ptr = N - 1;
    core_lat = 3;
    op_a[0] = 20; op_b[0] = 30;
    op_a[1] = 21; op_b[1] = 14;
    req = 4'b0011; pend = req;
    expect_txn(0, 0);
    expect_txn(0, 0);
    op_a[1] = 9; op_b[1] = 6;
    req = 4'b0010; pend = req;
    expect_txn(0, 0);

    // random rounds
    for (int r = 0; r < 25; r++) begin
      core_lat = $urandom_range(2, 12);
      for (int i = 0; i < N; i++) begin
        g = $urandom_range(1, 60);
        op_a[i] = W'(g * $urandom_range(0, 1000));
        op_b[i] = W'(g * $urandom_range(0, 1000));
        if ($urandom_range(0, 7) == 0) op_a[i] = '0;
        if ($urandom_range(0, 7) == 0) op_b[i] = '0;
      end
      pend = N'($urandom_range(1, 15));
      req  = pend;
      while (pend != '0) expect_txn(0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of test, expected finish before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule
